// File: rtl/conv_job_scheduler_pkg.sv
// conv_job_scheduler_pkg: shared widths, state/error encodings and the packed job word
package conv_job_scheduler_pkg;
  localparam int TS_W = 8;
  localparam int KS_W = 4;
  localparam int CH_W = 8;
  localparam int ST_W = 3;
  localparam int KN_W = 8;
  localparam int JOB_W = TS_W + KS_W + CH_W + ST_W + KN_W;
  typedef enum logic [2:0] {IDLE, CHECK, CALC, CLEAR, RUN, FLUSH, DONE} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_CFG, ERR_TIMEOUT, ERR_ABORT} err_t;
  typedef struct packed {
    logic [TS_W-1:0] tensor_size;
    logic [KS_W-1:0] kernel_size;
    logic [CH_W-1:0] channels;
    logic [ST_W-1:0] stride;
    logic [KN_W-1:0] kernel_nums;
  } job_t;
  function automatic logic cfg_bad(job_t j);
    return ~|j.stride || ~|j.kernel_size || (TS_W'(j.kernel_size) > j.tensor_size) ||
           ~|j.channels || ~|j.kernel_nums;
  endfunction
endpackage

// File: rtl/conv_job_scheduler_if.sv
// conv_job_scheduler_if: host job push, datapath control and status bundle
interface conv_job_scheduler_if;
  import conv_job_scheduler_pkg::*;
  logic job_valid;
  logic job_ready;
  logic [TS_W-1:0] job_tensor_size;
  logic [KS_W-1:0] job_kernel_size;
  logic [CH_W-1:0] job_channels;
  logic [ST_W-1:0] job_stride;
  logic [KN_W-1:0] job_kernel_nums;
  logic abort;
  logic dp_clear;
  logic dp_enable;
  logic [TS_W-1:0] cfg_tensor_size;
  logic [KS_W-1:0] cfg_kernel_size;
  logic [CH_W-1:0] cfg_channels;
  logic [ST_W-1:0] cfg_stride;
  logic [KN_W-1:0] cfg_kernel_nums;
  logic dp_w_done;
  logic [TS_W-1:0] out_dim;
  logic busy;
  logic job_done;
  logic job_err;
  logic [1:0] err_code;
  logic [15:0] jobs_completed;
  modport master (
    output job_valid, job_tensor_size, job_kernel_size, job_channels, job_stride, job_kernel_nums,
    output abort, dp_w_done,
    input job_ready, dp_clear, dp_enable, cfg_tensor_size, cfg_kernel_size, cfg_channels,
    input cfg_stride, cfg_kernel_nums, out_dim, busy, job_done, job_err, err_code, jobs_completed
  );
  modport slave (
    input job_valid, job_tensor_size, job_kernel_size, job_channels, job_stride, job_kernel_nums,
    input abort, dp_w_done,
    output job_ready, dp_clear, dp_enable, cfg_tensor_size, cfg_kernel_size, cfg_channels,
    output cfg_stride, cfg_kernel_nums, out_dim, busy, job_done, job_err, err_code, jobs_completed
  );
endinterface

// File: rtl/conv_job_scheduler_job_fifo.sv
// job_fifo: show-ahead synchronous FIFO of packed job words with full/empty/count
module job_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = ~|count;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign dout = mem[rd];
  // storage needs no reset: only slots below count are ever read
  always_ff @(posedge clk)
    if (push_ok) mem[wr] <= din;
  // pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr <= wr + AW'(1);
      if (pop_ok) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
endmodule

// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: queues, validates and sequences convolution jobs through the datapath
module conv_job_scheduler
  import conv_job_scheduler_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int TIMEOUT = 1_000_000,
  parameter int TO_W = 24
) (
  input logic clk,
  input logic rst,
  conv_job_scheduler_if.slave bus
);
  localparam int CW = $clog2(QDEPTH) + 1;
  state_t st, nxt;
  err_t ecode, err;
  job_t head, cfg;
  logic full, empty, pop, fin_ok, fin_err, ph, done_q, err_q;
  logic [CW-1:0] count;
  logic [TS_W-1:0] rem, q, out_dim;
  logic [TO_W-1:0] wd;
  logic [15:0] done_cnt;
  job_fifo #(.W(JOB_W), .DEPTH(QDEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(bus.job_valid),
    .pop(pop),
    .din({bus.job_tensor_size, bus.job_kernel_size, bus.job_channels, bus.job_stride, bus.job_kernel_nums}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign bus.job_ready = !full;
  assign bus.dp_clear = st == CLEAR || st == FLUSH;
  assign bus.dp_enable = st == RUN;
  assign bus.cfg_tensor_size = cfg.tensor_size;
  assign bus.cfg_kernel_size = cfg.kernel_size;
  assign bus.cfg_channels = cfg.channels;
  assign bus.cfg_stride = cfg.stride;
  assign bus.cfg_kernel_nums = cfg.kernel_nums;
  assign bus.out_dim = out_dim;
  assign bus.busy = st != IDLE || |count;
  assign bus.job_done = done_q;
  assign bus.job_err = err_q;
  assign bus.err_code = err;
  assign bus.jobs_completed = done_cnt;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  // next state and job outcome; save-complete outranks abort, abort outranks the watchdog
  always_comb begin
    nxt = st;
    pop = 1'b0;
    fin_ok = 1'b0;
    fin_err = 1'b0;
    ecode = ERR_NONE;
    case (st)
      IDLE: if (!empty) begin
        pop = 1'b1;
        nxt = CHECK;
      end
      CHECK: if (cfg_bad(cfg)) begin
        fin_err = 1'b1;
        ecode = ERR_CFG;
        nxt = IDLE;
      end else nxt = CALC;
      CALC: if (rem < TS_W'(cfg.stride)) nxt = CLEAR;
      CLEAR: if (ph) nxt = RUN;
      RUN: if (bus.dp_w_done) begin
        fin_ok = 1'b1;
        nxt = DONE;
      end else if (bus.abort || wd == TO_W'(TIMEOUT - 1)) begin
        fin_err = 1'b1;
        ecode = bus.abort ? ERR_ABORT : ERR_TIMEOUT;
        nxt = FLUSH;
      end
      FLUSH: if (ph) nxt = IDLE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // job config, output-dimension divider, clear phase, watchdog and status registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cfg <= '0;
      rem <= '0;
      q <= '0;
      out_dim <= '0;
      wd <= '0;
      ph <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      err <= ERR_NONE;
      done_cnt <= '0;
    end else begin
      done_q <= fin_ok;
      err_q <= fin_err;
      if (fin_ok || fin_err) err <= ecode;
      if (fin_ok) done_cnt <= done_cnt + 16'd1;
      if (pop) cfg <= head;
      if (st == CHECK) begin
        rem <= cfg.tensor_size - TS_W'(cfg.kernel_size);
        q <= '0;
      end
      if (st == CALC && rem >= TS_W'(cfg.stride)) begin
        rem <= rem - TS_W'(cfg.stride);
        q <= q + TS_W'(1);
      end
      if (st == CALC && rem < TS_W'(cfg.stride)) out_dim <= q + TS_W'(1);
      ph <= (st == CLEAR || st == FLUSH) && !ph;
      wd <= st == RUN ? wd + TO_W'(1) : '0;
    end
endmodule

// File: tb/tb_conv_job_scheduler.sv
// tb_conv_job_scheduler: scoreboard bench with a responder modelling the datapath save strobe
module tb_conv_job_scheduler;
  import conv_job_scheduler_pkg::*;
  localparam int TIMEOUT = 16;
  typedef struct {
    job_t job;
    logic ok;
    logic [1:0] code;
    int dim;
  } exp_t;
  typedef struct {
    int mode;
    int d;
  } plan_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  conv_job_scheduler_if bus();
  conv_job_scheduler #(.QDEPTH(4), .TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  exp_t exp_q[$];
  plan_t plan_q[$];
  plan_t cur;
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int clr_run = 0;
  int rc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not allowed or bound expired", name);
  endtask

  // mode 0: save strobe at RUN cycle d; 1: never (watchdog); 2: abort from cycle d; 3: abort+save at d
  task automatic push_job(input int h, input int k, input int c, input int s, input int n,
                          input int mode, input int d);
    exp_t e;
    plan_t p;
    int t = 0;
    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_tensor_size = TS_W'(h);
    bus.job_kernel_size = KS_W'(k);
    bus.job_channels = CH_W'(c);
    bus.job_stride = ST_W'(s);
    bus.job_kernel_nums = KN_W'(n);
    while (!bus.job_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) fail("push_wait");
    @(posedge clk);
    e.job.tensor_size = TS_W'(h);
    e.job.kernel_size = KS_W'(k);
    e.job.channels = CH_W'(c);
    e.job.stride = ST_W'(s);
    e.job.kernel_nums = KN_W'(n);
    if (s == 0 || k == 0 || k > h || c == 0 || n == 0) begin
      e.ok = 1'b0;
      e.code = 2'd1;
      e.dim = 0;
    end else begin
      e.dim = (h - k) / s + 1;
      e.ok = mode == 0 || mode == 3;
      e.code = mode == 1 ? 2'd2 : mode == 2 ? 2'd3 : 2'd0;
      p.mode = mode;
      p.d = d;
      plan_q.push_back(p);
    end
    exp_q.push_back(e);
    #1 bus.job_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bus.busy || exp_q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail("drain_timeout");
  endtask

  task automatic push_random();
    int h, k, c, s, n;
    h = $urandom_range(1, 40);
    k = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 8);
    c = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 255);
    s = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 7);
    n = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 255);
    push_job(h, k, c, s, n, $urandom_range(0, 3), $urandom_range(1, TIMEOUT - 1));
  endtask

  // datapath responder: plays each RUN job's plan, injects ignored noise outside RUN, checks RUN length
  initial begin
    bus.dp_w_done = 1'b0;
    bus.abort = 1'b0;
    cur.mode = 0;
    cur.d = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        rc = 0;
        bus.dp_w_done = 1'b0;
        bus.abort = 1'b0;
      end else if (bus.dp_enable) begin
        if (rc == 0) begin
          if (plan_q.size() == 0) begin
            fail("unexpected_run");
            cur.mode = 1;
          end else cur = plan_q.pop_front();
        end
        rc++;
        bus.dp_w_done = (cur.mode == 0 || cur.mode == 3) && rc == cur.d;
        bus.abort = (cur.mode == 2 && rc >= cur.d) || (cur.mode == 3 && rc == cur.d);
      end else begin
        if (rc != 0) check("run_len", 64'(rc), 64'(cur.mode == 1 ? TIMEOUT : cur.d));
        rc = 0;
        bus.dp_w_done = $urandom_range(0, 3) == 0;
        bus.abort = $urandom_range(0, 3) == 0;
      end
    end
  end

  // monitor: scoreboard pop on every completion pulse, clear-pulse length check
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      clr_run = 0;
      done_cnt = 0;
    end else begin
      if (bus.dp_clear) clr_run++;
      else if (clr_run != 0) begin
        check("clear_len", 64'(clr_run), 64'd2);
        clr_run = 0;
      end
      if (bus.job_done || bus.job_err) begin
        if (exp_q.size() == 0) fail("unexpected_pulse");
        else begin
          e = exp_q.pop_front();
          check("pulse_kind", 64'({bus.job_done, bus.job_err}), e.ok ? 64'd2 : 64'd1);
          check("err_code", 64'(bus.err_code), 64'(e.code));
          check("cfg", 64'({bus.cfg_tensor_size, bus.cfg_kernel_size, bus.cfg_channels,
                            bus.cfg_stride, bus.cfg_kernel_nums}), 64'(e.job));
          if (e.code != 2'd1) check("out_dim", 64'(bus.out_dim), 64'(e.dim));
          if (e.ok) begin
            done_cnt++;
            check("jobs_completed", 64'(bus.jobs_completed), 64'(done_cnt));
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  initial begin
    int n;
    bus.job_valid = 1'b0;
    bus.job_tensor_size = '0;
    bus.job_kernel_size = '0;
    bus.job_channels = '0;
    bus.job_stride = '0;
    bus.job_kernel_nums = '0;
    repeat (3) @(negedge clk);
    check("rst_job_ready", 64'(bus.job_ready), 64'd1);
    check("rst_dp", 64'({bus.dp_clear, bus.dp_enable}), 64'd0);
    check("rst_pulses", 64'({bus.job_done, bus.job_err, bus.busy}), 64'd0);
    check("rst_cfg", 64'({bus.cfg_tensor_size, bus.cfg_kernel_size, bus.cfg_channels,
                          bus.cfg_stride, bus.cfg_kernel_nums}), 64'd0);
    check("rst_status", 64'({bus.out_dim, bus.err_code, bus.jobs_completed}), 64'd0);
    rst = 1'b0;
    push_job(8, 3, 3, 1, 2, 0, 12);
    n = 0;
    @(negedge clk);
    while (!bus.dp_clear && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("calc_latency", 64'(n), 64'd8);
    wait_idle();
    check("first_done_count", 64'(bus.jobs_completed), 64'd1);
    check("first_enable_low", 64'(bus.dp_enable), 64'd0);
    push_job(7, 3, 1, 2, 1, 0, 5);
    push_job(5, 5, 1, 3, 1, 0, 3);
    push_job(3, 4, 1, 1, 1, 0, 3);
    push_job(8, 3, 1, 0, 1, 0, 3);
    wait_idle();
    check("bad_cfg_held", 64'(bus.err_code), 64'd1);
    push_job(10, 3, 2, 1, 1, 0, 15);
    n = 0;
    while (!bus.dp_enable && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("fill_wait_run");
    for (int i = 0; i < 4; i++) push_job(6 + i, 2, 1, 1, 1, 0, 2 + i);
    @(negedge clk);
    check("queue_full_ready", 64'(bus.job_ready), 64'd0);
    push_job(11, 2, 1, 3, 1, 0, 4);
    wait_idle();
    push_job(6, 2, 1, 1, 1, 1, 0);
    push_job(6, 2, 1, 2, 1, 0, 4);
    push_job(9, 3, 1, 3, 1, 3, 7);
    wait_idle();
    check("abort_and_done", 64'(bus.err_code), 64'd0);
    push_job(12, 3, 1, 1, 1, 0, 15);
    push_job(9, 3, 1, 1, 1, 0, 5);
    push_job(9, 3, 1, 1, 1, 0, 5);
    n = 0;
    while (rc < 10 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("reset_wait_run");
    #2 rst = 1'b1;
    #1;
    check("async_rst_enable", 64'(bus.dp_enable), 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_ready", 64'(bus.job_ready), 64'd1);
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(negedge clk);
    check("rst_count_cleared", 64'(bus.jobs_completed), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_lost", 64'(bus.busy), 64'd0);
    push_job(8, 3, 3, 1, 2, 0, 6);
    wait_idle();
    for (int i = 0; i < 40; i++) begin
      push_random();
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
